// File: rtl/cart_bus_bridge.sv
// Halfword-to-word bridge: pairs 16-bit upstream accesses into 32-bit downstream
// register-bus transfers, with a one-word read latch and a read timeout.
module cart_bus_bridge #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pi_request,
    input  logic        i_pi_write,
    input  logic [11:0] i_pi_address,
    input  logic [15:0] i_pi_data,
    output logic        o_pi_busy,
    output logic        o_pi_ack,
    output logic [15:0] o_pi_data,
    output logic        o_timeout,
    output logic        o_request,
    output logic        o_write,
    input  logic        i_busy,
    input  logic        i_ack,
    output logic [10:0] o_address,
    output logic [31:0] o_data,
    input  logic [31:0] i_data
);

    // Downstream handshake: a request transfers on a rising edge where
    // o_request=1 and i_busy=0; read data arrives later as a single i_ack strobe.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = TIMEOUT - 8'd1;

    state_t      state;
    state_t      state_next;

    logic [10:0] addr_q;
    logic        half_q;
    logic        is_rd_q;
    logic [15:0] hi_q;
    logic [31:0] data_q;
    logic [31:0] latch_q;
    logic [10:0] latch_addr_q;
    logic        latch_valid_q;
    logic [7:0]  cnt_q;

    logic        accept;
    logic        latch_hit;
    logic        timeout_hit;
    logic        rd_capture;
    logic        rd_abort;
    logic        wr_xfer;

    assign accept      = (state == IDLE) && i_pi_request;
    assign latch_hit   = latch_valid_q && (latch_addr_q == i_pi_address[11:1]);
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);
    assign wr_xfer     = (state == WR_REQ) && !i_busy;
    assign o_address   = addr_q;
    assign o_data      = data_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_capture = 1'b0;
        rd_abort   = 1'b0;
        o_pi_busy  = (state != IDLE);
        o_pi_ack   = 1'b0;
        o_pi_data  = 16'h0000;
        o_timeout  = 1'b0;
        o_request  = 1'b0;
        o_write    = 1'b0;
        case (state)
            IDLE: begin
                if (i_pi_request) begin
                    if (i_pi_write) begin
                        state_next = i_pi_address[0] ? WR_REQ : RESP;
                    end else if (i_pi_address[0] && latch_hit) begin
                        state_next = RESP;
                    end else begin
                        state_next = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                o_request = 1'b1;
                o_write   = 1'b1;
                if (!i_busy) begin
                    state_next = RESP;
                end
            end
            RD_REQ: begin
                // The request is withdrawn in the abandon cycle so no transfer races the timeout.
                if (timeout_hit) begin
                    rd_abort   = 1'b1;
                    o_timeout  = 1'b1;
                    state_next = RESP;
                end else begin
                    o_request = 1'b1;
                    if (!i_busy && i_ack) begin
                        rd_capture = 1'b1;
                        state_next = RESP;
                    end else if (!i_busy) begin
                        state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (i_ack) begin
                    rd_capture = 1'b1;
                    state_next = RESP;
                end else if (timeout_hit) begin
                    rd_abort   = 1'b1;
                    o_timeout  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                o_pi_ack = 1'b1;
                if (is_rd_q) begin
                    o_pi_data = half_q ? latch_q[15:0] : latch_q[31:16];
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr_q        <= 11'h000;
            half_q        <= 1'b0;
            is_rd_q       <= 1'b0;
            hi_q          <= 16'h0000;
            data_q        <= 32'h0000_0000;
            latch_q       <= 32'h0000_0000;
            latch_addr_q  <= 11'h000;
            latch_valid_q <= 1'b0;
            cnt_q         <= 8'h00;
        end else begin
            if (accept) begin
                addr_q  <= i_pi_address[11:1];
                half_q  <= i_pi_address[0];
                is_rd_q <= !i_pi_write;
                cnt_q   <= 8'h00;
                if (i_pi_write && !i_pi_address[0]) begin
                    hi_q <= i_pi_data;
                end
                if (i_pi_write && i_pi_address[0]) begin
                    data_q <= {hi_q, i_pi_data};
                end
            end else if ((state == RD_REQ) || (state == RD_WAIT)) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (rd_capture) begin
                latch_q       <= i_data;
                latch_addr_q  <= addr_q;
                latch_valid_q <= 1'b1;
            end else if (rd_abort) begin
                latch_q       <= 32'hFFFF_FFFF;
                latch_valid_q <= 1'b0;
            end else if (wr_xfer && latch_valid_q && (latch_addr_q == addr_q)) begin
                latch_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cart_bus_bridge.sv
// Bench for cart_bus_bridge: scripted upstream accesses, a downstream responder
// model, and a scoreboard that checks ack latency, read data and transfers.
module tb_cart_bus_bridge;

    localparam logic [7:0] TO = 8'd16;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic        i_pi_request = 1'b0;
    logic        i_pi_write = 1'b0;
    logic [11:0] i_pi_address = 12'h000;
    logic [15:0] i_pi_data = 16'h0000;
    logic        o_pi_busy;
    logic        o_pi_ack;
    logic [15:0] o_pi_data;
    logic        o_timeout;
    logic        o_request;
    logic        o_write;
    logic        i_busy = 1'b0;
    logic        i_ack = 1'b0;
    logic [10:0] o_address;
    logic [31:0] o_data;
    logic [31:0] i_data = 32'h0;

    cart_bus_bridge #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_pi_request(i_pi_request), .i_pi_write(i_pi_write),
        .i_pi_address(i_pi_address), .i_pi_data(i_pi_data),
        .o_pi_busy(o_pi_busy), .o_pi_ack(o_pi_ack), .o_pi_data(o_pi_data),
        .o_timeout(o_timeout), .o_request(o_request), .o_write(o_write),
        .i_busy(i_busy), .i_ack(i_ack), .o_address(o_address),
        .o_data(o_data), .i_data(i_data)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=running required=done");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [24:0] exp_q[$];       // {ack latency, check data, read halfword}
    logic [43:0] exp_xfer_q[$];  // {write, word address, write word}
    logic [24:0] e;
    logic [43:0] x;

    int neg_cnt = 0, acc_neg = 0, xfers = 0, req_cycles = 0, to_seen = 0, exp_to_lat = 0;
    int busy_left = 0, ack_delay = 1, ack_cnt = 0;
    logic [31:0] rsp_data = 32'h0;
    logic        ack_seen = 1'b0;
    logic        addr_changed = 1'b0;
    logic [10:0] first_addr = 11'h0;

    logic        m_valid = 1'b0;
    logic [10:0] m_addr = 11'h0;
    logic [31:0] m_latch = 32'h0;
    logic [15:0] m_hi = 16'h0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_busy", o_pi_busy, 0);
        check_eq("rst_ack", o_pi_ack, 0);
        check_eq("rst_timeout", o_timeout, 0);
        check_eq("rst_request", o_request, 0);
        check_eq("rst_write", o_write, 0);
        check_eq("rst_pi_data", o_pi_data, 0);
        check_eq("rst_address", o_address, 0);
        check_eq("rst_data", o_data, 0);
    endtask

    // Monitor, scoreboard and downstream responder share one negedge process.
    always @(negedge i_clk) begin
        neg_cnt++;
        i_ack = 1'b0;
        if (!i_reset_n) begin
            i_busy  = 1'b0;
            ack_cnt = 0;
        end else begin
            if (i_pi_request && !o_pi_busy) acc_neg = neg_cnt;
            if (o_pi_ack) begin
                ack_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check_eq("ack_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("ack_latency", neg_cnt - acc_neg, e[24:17]);
                    if (e[16]) check_eq("rd_data", o_pi_data, e[15:0]);
                end
            end
            if (o_timeout) begin
                to_seen++;
                check_eq("timeout_latency", neg_cnt - acc_neg, exp_to_lat);
            end
            if (o_request) begin
                req_cycles++;
                if (req_cycles == 1) first_addr = o_address;
                else if (o_address != first_addr) addr_changed = 1'b1;
                if (busy_left > 0) begin
                    i_busy = 1'b1;
                    busy_left--;
                end else begin
                    i_busy = 1'b0;
                    xfers++;
                    if (exp_xfer_q.size() == 0) begin
                        check_eq("xfer_unexpected", 1, 0);
                    end else begin
                        x = exp_xfer_q.pop_front();
                        check_eq("xfer_write", o_write, x[43]);
                        check_eq("xfer_addr", o_address, x[42:32]);
                        if (x[43]) check_eq("xfer_data", o_data, x[31:0]);
                    end
                    if (!o_write && ack_delay == 0) begin
                        i_ack  = 1'b1;
                        i_data = rsp_data;
                    end else if (!o_write && ack_delay > 0) begin
                        ack_cnt = ack_delay;
                    end
                end
            end else begin
                i_busy = 1'b0;
                if (ack_cnt > 0) begin
                    ack_cnt--;
                    if (ack_cnt == 0) begin
                        i_ack  = 1'b1;
                        i_data = rsp_data;
                    end
                end
            end
        end
    end

    task automatic wait_ack();
        for (int i = 0; i < 300 && !ack_seen; i++) @(posedge i_clk);
        if (!ack_seen) begin
            check_eq("ack_wait", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic pi_access(input logic wr, input logic [11:0] addr, input logic [15:0] wdata,
                             input logic chk_data, input logic [15:0] exp_data, input int lat,
                             input logic stray);
        @(posedge i_clk); #1;
        i_pi_request = 1'b1;
        i_pi_write   = wr;
        i_pi_address = addr;
        i_pi_data    = wdata;
        exp_q.push_back({lat[7:0], chk_data, exp_data});
        ack_seen = 1'b0;
        @(posedge i_clk); #1;
        i_pi_request = 1'b0;
        if (stray) begin
            @(posedge i_clk); #1;
            i_pi_request = 1'b1;
            i_pi_write   = 1'b1;
            i_pi_address = 12'h0C0;
            i_pi_data    = 16'hAAAA;
            @(posedge i_clk); #1;
            i_pi_request = 1'b0;
        end
        wait_ack();
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [15:0] data);
        int x0;
        x0 = xfers;
        if (!addr[0]) begin
            m_hi = data;
            pi_access(1'b1, addr, data, 1'b0, 16'h0, 1, 1'b0);
            check_eq("wr_hi_xfers", xfers - x0, 0);
        end else begin
            exp_xfer_q.push_back({1'b1, addr[11:1], m_hi, data});
            if (m_valid && m_addr == addr[11:1]) m_valid = 1'b0;
            busy_left = 0;
            req_cycles = 0;
            pi_access(1'b1, addr, data, 1'b0, 16'h0, 2, 1'b0);
            check_eq("wr_lo_xfers", xfers - x0, 1);
        end
    endtask

    task automatic do_read(input logic [11:0] addr, input int busy, input int delay,
                           input logic [31:0] data, input logic stray);
        logic        hit;
        logic [15:0] exp;
        int          lat;
        int          x0;
        hit = addr[0] && m_valid && (m_addr == addr[11:1]);
        busy_left = busy;
        ack_delay = delay;
        rsp_data = data;
        req_cycles = 0;
        addr_changed = 1'b0;
        if (hit) begin
            exp = m_latch[15:0];
            lat = 1;
        end else begin
            exp_xfer_q.push_back({1'b0, addr[11:1], 32'h0});
            if (delay < 0) begin
                m_latch = 32'hFFFF_FFFF;
                m_valid = 1'b0;
                lat = int'(TO) + 1;
                exp_to_lat = int'(TO);
            end else begin
                m_latch = data;
                m_valid = 1'b1;
                m_addr = addr[11:1];
                lat = 2 + busy + delay;
            end
            exp = addr[0] ? m_latch[15:0] : m_latch[31:16];
        end
        x0 = xfers;
        pi_access(1'b0, addr, 16'h0, 1'b1, exp, lat, stray);
        check_eq("rd_xfers", xfers - x0, hit ? 0 : 1);
        if (!hit) begin
            check_eq("rd_req_cycles", req_cycles, busy + 1);
            check_eq("rd_addr_stable", addr_changed, 0);
        end
    endtask

    initial begin
        int t0, w, h;
        #1 i_reset_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge i_clk);
        #2 i_reset_n = 1'b1;

        do_write(12'h00E, 16'h1234);
        do_write(12'h00F, 16'h5678);

        do_read(12'h004, 0, 1, 32'h5336_3461, 1'b0);
        do_read(12'h005, 0, 1, 32'h0, 1'b0);

        do_read(12'h801, 0, 1, 32'hA5A5_0F0F, 1'b0);
        do_read(12'h010, 5, 1, 32'h1357_9BDF, 1'b0);

        // Lower write to the latched word must force the next lower read downstream.
        do_write(12'h011, 16'h4444);
        do_read(12'h011, 0, 0, 32'h2468_ACE0, 1'b0);

        do_read(12'h060, 0, 3, 32'hCAFE_F00D, 1'b1);
        do_write(12'h0C1, 16'h0001);

        t0 = to_seen;
        do_read(12'h022, 0, -1, 32'h0, 1'b0);
        check_eq("timeout_count", to_seen - t0, 1);
        do_read(12'h023, 0, 1, 32'h0BAD_F00D, 1'b0);

        for (int k = 0; k < 8; k++) begin
            w = $urandom_range(0, 3);
            h = $urandom_range(0, 1);
            do_read({w[10:0], h[0]}, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 1'b0);
        end

        do_read(12'h050, 0, 1, 32'h7777_8888, 1'b0);

        // Abandon a read in RD_WAIT via reset.
        busy_left = 0;
        ack_delay = -1;
        ack_seen = 1'b0;
        exp_xfer_q.push_back({1'b0, 11'h010, 32'h0});
        @(posedge i_clk); #1;
        i_pi_request = 1'b1;
        i_pi_write   = 1'b0;
        i_pi_address = 12'h020;
        @(posedge i_clk); #1;
        i_pi_request = 1'b0;
        repeat (3) @(posedge i_clk);
        #3 i_reset_n = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        exp_xfer_q.delete();
        m_valid = 1'b0;
        m_hi = 16'h0;
        m_latch = 32'h0;
        repeat (2) @(negedge i_clk);
        #2 i_reset_n = 1'b1;
        repeat (20) @(posedge i_clk);
        check_eq("no_ack_after_reset", ack_seen, 0);
        check_eq("idle_after_reset", o_pi_busy, 0);

        do_write(12'h041, 16'hBEEF);
        do_read(12'h051, 0, 1, 32'h1111_2222, 1'b0);

        repeat (3) @(posedge i_clk);
        check_eq("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
